// File: rtl/axis_arb_pkg.sv
// Shared definitions for the packet arbiter: FSM state encoding and the
// round-robin next-grant function used by axis_rr_select.
package axis_arb_pkg;

  localparam int MAX_S_COUNT   = 8;
  localparam int MAX_SEL_WIDTH = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // First requester after 'last', wrapping modulo count; returns 'last' if nobody requests.
  function automatic logic [MAX_SEL_WIDTH-1:0] rr_next(
    input logic [MAX_S_COUNT-1:0]   req,
    input logic [MAX_SEL_WIDTH-1:0] last,
    input int                       count
  );
    logic [MAX_SEL_WIDTH-1:0] result;
    logic                     found;
    int                       idx;
    result = last;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= MAX_S_COUNT; k++) begin
      if ((k <= count) && (count > 0)) begin
        idx = (int'(last) + k) % count;
        if (!found && req[idx[MAX_SEL_WIDTH-1:0]]) begin
          result = idx[MAX_SEL_WIDTH-1:0];
          found  = 1'b1;
        end else begin
          found  = found;
        end
      end else begin
        found = found;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_rr_select.sv
// Combinational round-robin priority encoder: picks the next requester
// after last_grant and flags whether any request is pending.
module axis_rr_select
  import axis_arb_pkg::*;
#(
  parameter int S_COUNT   = 2,
  parameter int SEL_WIDTH = $clog2(S_COUNT)
) (
  input  logic [S_COUNT-1:0]   req,
  input  logic [SEL_WIDTH-1:0] last_grant,
  output logic [SEL_WIDTH-1:0] grant,
  output logic                 any_req
);

  logic [MAX_S_COUNT-1:0]   req_ext_s;
  logic [MAX_SEL_WIDTH-1:0] last_ext_s;
  logic [MAX_SEL_WIDTH-1:0] next_s;

  // Widen to the package's fixed function width and select the next grant.
  always_comb begin
    req_ext_s                   = '0;
    req_ext_s[S_COUNT-1:0]      = req;
    last_ext_s                  = '0;
    last_ext_s[SEL_WIDTH-1:0]   = last_grant;
    next_s                      = rr_next(req_ext_s, last_ext_s, S_COUNT);
    grant                       = next_s[SEL_WIDTH-1:0];
    any_req                     = |req;
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter: holds a grant until tlast.
// Optional m_axis_tid output (source index) enabled by macro AXIS_ARB_TID_EN.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int S_COUNT    = 2,
  parameter  int DATA_WIDTH = 32,
  localparam int SEL_WIDTH  = $clog2(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast
`ifdef AXIS_ARB_TID_EN
  ,
  output logic [SEL_WIDTH-1:0]          m_axis_tid
`endif
);

  arb_state_t           state_r;
  logic [SEL_WIDTH-1:0] grant_r;
  logic [SEL_WIDTH-1:0] last_grant_r;
  logic [SEL_WIDTH-1:0] sel_s;
  logic                 any_req_s;

  axis_rr_select #(
    .S_COUNT   (S_COUNT),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_sel (
    .req        (s_axis_tvalid),
    .last_grant (last_grant_r),
    .grant      (sel_s),
    .any_req    (any_req_s)
  );

  // Arbitration FSM: grant on request in IDLE, release after the accepted tlast beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      last_grant_r <= SEL_WIDTH'(S_COUNT - 1);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            grant_r <= sel_s;
            state_r <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            state_r      <= ST_IDLE;
            last_grant_r <= grant_r;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Zero-latency mux from the granted source; everything quiet outside BUSY.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_r == ST_BUSY) begin
      m_axis_tdata           = s_axis_tdata[int'(grant_r)*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tvalid          = s_axis_tvalid[grant_r];
      m_axis_tlast           = s_axis_tlast[grant_r];
      s_axis_tready[grant_r] = m_axis_tready;
    end else begin
      s_axis_tready = '0;
    end
  end

`ifdef AXIS_ARB_TID_EN
  // Source tag follows the grant only while a packet is in flight.
  always_comb begin
    if (state_r == ST_BUSY) begin
      m_axis_tid = grant_r;
    end else begin
      m_axis_tid = '0;
    end
  end
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed self-checking bench for axis_pkt_arbiter (two sources, 32-bit data).
// With AXIS_ARB_TID_EN defined it also checks m_axis_tid on every beat.
module tb_axis_pkt_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_tdata;
  logic [1:0]  s_tvalid;
  logic [1:0]  s_tready;
  logic [1:0]  s_tlast;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
`ifdef AXIS_ARB_TID_EN
  logic [0:0]  m_tid;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          c;
    logic [31:0] d;
    logic        l;
    int          tid;
  } beat_t;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  beat_t       out_q[$];
  logic [31:0] held_q[$];
  int          cyc;
  logic [63:0] nrdy_mask;
  logic [63:0] hold0_mask;
  logic        hold0;
  logic        rdy1_seen;

  axis_pkt_arbiter #(
    .S_COUNT    (2),
    .DATA_WIDTH (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
`ifdef AXIS_ARB_TID_EN
    ,
    .m_axis_tid    (m_tid)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present the head of each source queue.
  task automatic drive();
    s_tvalid[0]     = (q0.size() > 0) && !hold0;
    s_tdata[31:0]   = (q0.size() > 0) ? q0[0][31:0] : 32'h0;
    s_tlast[0]      = (q0.size() > 0) ? q0[0][32] : 1'b0;
    s_tvalid[1]     = (q1.size() > 0);
    s_tdata[63:32]  = (q1.size() > 0) ? q1[0][31:0] : 32'h0;
    s_tlast[1]      = (q1.size() > 0) ? q1[0][32] : 1'b0;
  endtask

  task automatic step_cycle();
    beat_t b;
    @(negedge clk);
    m_tready = (cyc < 64) ? !nrdy_mask[cyc] : 1'b1;
    hold0    = (cyc < 64) ? hold0_mask[cyc] : 1'b0;
    drive();
    #1;
    if (s_tready[1]) rdy1_seen = 1'b1;
    if (m_tvalid && !m_tready) held_q.push_back(m_tdata);
    if (m_tvalid && m_tready) begin
      b.c = cyc;
      b.d = m_tdata;
      b.l = m_tlast;
`ifdef AXIS_ARB_TID_EN
      b.tid = int'(m_tid);
`else
      b.tid = 0;
`endif
      out_q.push_back(b);
    end
    if (s_tvalid[0] && s_tready[0]) void'(q0.pop_front());
    if (s_tvalid[1] && s_tready[1]) void'(q1.pop_front());
    cyc++;
  endtask

  task automatic run(input int n);
    cyc       = 0;
    rdy1_seen = 1'b0;
    out_q.delete();
    held_q.delete();
    repeat (n) step_cycle();
    nrdy_mask  = '0;
    hold0_mask = '0;
  endtask

  task automatic expect_beat(input int k, input int c, input logic [31:0] d,
                             input logic l, input int src);
    if (k < out_q.size()) begin
      check($sformatf("beat%0d_cycle", k), 32'(out_q[k].c), 32'(c));
      check($sformatf("beat%0d_data", k), out_q[k].d, d);
      check($sformatf("beat%0d_last", k), {31'h0, out_q[k].l}, {31'h0, l});
`ifdef AXIS_ARB_TID_EN
      check($sformatf("beat%0d_tid", k), 32'(out_q[k].tid), 32'(src));
`else
      if (src < 0) $display("note: negative source index %0d", src);
`endif
    end else begin
      check($sformatf("beat%0d_missing", k), 32'(out_q.size()), 32'(k + 1));
    end
  endtask

  task automatic push(input int src, input logic [31:0] d, input logic l);
    if (src == 0) q0.push_back({l, d});
    else          q1.push_back({l, d});
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    hold0 = 1'b0;
    drive();
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("rst_tvalid", {31'h0, m_tvalid}, 32'h0);
      check("rst_tready", {30'h0, s_tready}, 32'h0);
      check("rst_tdata", m_tdata, 32'h0);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    m_tready   = 1'b1;
    nrdy_mask  = '0;
    hold0_mask = '0;
    hold0      = 1'b0;
    s_tdata    = '0;
    s_tvalid   = '0;
    s_tlast    = '0;

    // Reset then idle
    do_reset();
    run(3);
    check("idle_nbeats", 32'(out_q.size()), 32'd0);

    // Contention round 1 from reset: src0 first, 1-cycle bubble, then src1
    for (int i = 1; i <= 3; i++) push(0, 32'(i), i == 3);
    for (int i = 10; i <= 12; i++) push(1, 32'(i), i == 12);
    run(9);
    check("cont1_nbeats", 32'(out_q.size()), 32'd6);
    expect_beat(0, 1, 32'h1, 1'b0, 0);
    expect_beat(1, 2, 32'h2, 1'b0, 0);
    expect_beat(2, 3, 32'h3, 1'b1, 0);
    expect_beat(3, 5, 32'hA, 1'b0, 1);
    expect_beat(4, 6, 32'hB, 1'b0, 1);
    expect_beat(5, 7, 32'hC, 1'b1, 1);

    // Single source: 6-beat packet on src0
    for (int i = 1; i <= 6; i++) push(0, 32'(i), i == 6);
    run(8);
    check("single_nbeats", 32'(out_q.size()), 32'd6);
    for (int i = 1; i <= 6; i++) expect_beat(i - 1, i, 32'(i), i == 6, 0);
    check("single_rdy1_low", {31'h0, rdy1_seen}, 32'h0);

    // Contention round 2: src0 won last, so src1 goes first
    push(0, 32'h4, 1'b0);
    push(0, 32'h5, 1'b1);
    push(1, 32'hD, 1'b0);
    push(1, 32'hE, 1'b1);
    run(7);
    check("cont2_nbeats", 32'(out_q.size()), 32'd4);
    expect_beat(0, 1, 32'hD, 1'b0, 1);
    expect_beat(1, 2, 32'hE, 1'b1, 1);
    expect_beat(2, 4, 32'h4, 1'b0, 0);
    expect_beat(3, 5, 32'h5, 1'b1, 0);

    // Backpressure after beat 2 for 5 cycles, src1 waiting
    do_reset();
    for (int i = 1; i <= 6; i++) push(0, 32'h10 + 32'(i), i == 6);
    push(1, 32'h21, 1'b1);
    nrdy_mask = 64'h0000_0000_0000_00F8;
    run(15);
    check("bp_nbeats", 32'(out_q.size()), 32'd7);
    check("bp_held_count", 32'(held_q.size()), 32'd5);
    for (int i = 0; i < held_q.size(); i++) check($sformatf("bp_held%0d", i), held_q[i], 32'h13);
    expect_beat(0, 1, 32'h11, 1'b0, 0);
    expect_beat(1, 2, 32'h12, 1'b0, 0);
    expect_beat(2, 8, 32'h13, 1'b0, 0);
    expect_beat(3, 9, 32'h14, 1'b0, 0);
    expect_beat(4, 10, 32'h15, 1'b0, 0);
    expect_beat(5, 11, 32'h16, 1'b1, 0);
    expect_beat(6, 13, 32'h21, 1'b1, 1);

    // Source stall: src0 drops tvalid 3 cycles, src1 keeps requesting
    for (int i = 1; i <= 5; i++) push(0, 32'h30 + 32'(i), i == 5);
    push(1, 32'h41, 1'b1);
    hold0_mask = 64'h0000_0000_0000_0038;
    run(12);
    check("stall_nbeats", 32'(out_q.size()), 32'd6);
    expect_beat(0, 1, 32'h31, 1'b0, 0);
    expect_beat(1, 2, 32'h32, 1'b0, 0);
    expect_beat(2, 6, 32'h33, 1'b0, 0);
    expect_beat(3, 7, 32'h34, 1'b0, 0);
    expect_beat(4, 8, 32'h35, 1'b1, 0);
    expect_beat(5, 10, 32'h41, 1'b1, 1);

    // Reset mid-packet after beat 2: outputs drop before the next clock edge
    for (int i = 1; i <= 6; i++) push(0, 32'h50 + 32'(i), i == 6);
    run(3);
    check("mid_nbeats", 32'(out_q.size()), 32'd2);
    @(negedge clk);
    drive();
    #1;
    check("mid_pre_tvalid", {31'h0, m_tvalid}, 32'h1);
    check("mid_pre_tdata", m_tdata, 32'h53);
    #1;
    rst = 1'b1;
    #1;
    check("mid_async_tvalid", {31'h0, m_tvalid}, 32'h0);
    check("mid_async_tready", {30'h0, s_tready}, 32'h0);
    q0.delete();
    q1.delete();
    drive();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push(0, 32'h61, 1'b1);
    push(1, 32'h71, 1'b1);
    run(5);
    check("post_rst_nbeats", 32'(out_q.size()), 32'd2);
    expect_beat(0, 1, 32'h61, 1'b1, 0);
    expect_beat(1, 3, 32'h71, 1'b1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
